// File: rtl/axis_pkt_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_mux_rr
//  Description : NUM_CH-input AXI4-Stream packet multiplexer with
//                packet-granular round-robin arbitration. A granted channel
//                owns the output until its tlast handshake; one arbitration
//                bubble separates consecutive packets.
//                Optional feature macro AXIS_MUX_SRC_TAG_EN: when defined,
//                m_axis_tuser[SRC_TAG_LSB +: clog2(NUM_CH)] carries grant_id.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_mux_rr #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int USER_WIDTH  = 128,
    parameter int SRC_TAG_LSB = 32
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_CH*USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_CH-1:0]              s_axis_tvalid,
    input  logic [NUM_CH-1:0]              s_axis_tlast,
    output logic [NUM_CH-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]        m_axis_tstrb,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [$clog2(NUM_CH)-1:0]      grant_id,
    output logic                           busy
);

    localparam int c_GW  = $clog2(NUM_CH);
    localparam int c_GW1 = c_GW + 1;
    localparam int c_SW  = DATA_WIDTH / 8;

    localparam logic [c_GW:0]   c_NUM      = c_GW1'(NUM_CH);
    localparam logic [c_GW:0]   c_ONE      = c_GW1'(1);
    localparam logic [c_GW-1:0] c_LAST_CH  = c_GW'(NUM_CH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_GW-1:0] r_grant;
    logic [c_GW-1:0] r_last_grant;

    // Elaboration-time sanity check on the configuration
    generate
        if (NUM_CH < 2 || NUM_CH > 16 || SRC_TAG_LSB < 0) begin : g_param_check
            $error("axis_pkt_mux_rr: unsupported parameter set");
        end
    endgenerate

    // Per-channel views of the flattened input buses
    logic [DATA_WIDTH-1:0] w_tdata_a [NUM_CH];
    logic [c_SW-1:0]       w_tstrb_a [NUM_CH];
    logic [USER_WIDTH-1:0] w_tuser_a [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_tdata_a[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_tstrb_a[gi] = s_axis_tstrb[gi*c_SW +: c_SW];
            assign w_tuser_a[gi] = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
        end
    endgenerate

    // Round-robin pick: rotate the request vector so that bit 0 is the
    // channel right after last_grant, find the lowest set bit, then map the
    // offset back to an absolute channel number modulo NUM_CH.
    logic [2*NUM_CH-1:0] w_req2;
    logic [NUM_CH-1:0]   w_rot;
    logic [c_GW:0]       w_start;
    logic [c_GW:0]       w_off;
    logic [c_GW:0]       w_sum;
    logic [c_GW-1:0]     w_pick;

    assign w_req2  = {s_axis_tvalid, s_axis_tvalid};
    assign w_start = {1'b0, r_last_grant} + c_ONE;
    assign w_rot   = NUM_CH'(w_req2 >> w_start);

    // Lowest-index requester in the rotated vector wins
    always_comb begin
        w_off = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = c_GW1'(j);
            end
        end
    end

    assign w_sum  = w_start + w_off;
    assign w_pick = (w_sum >= c_NUM) ? c_GW'(w_sum - c_NUM) : c_GW'(w_sum);

    // Zero-latency pass-through of the granted channel while busy; all
    // outputs are held at zero while idle or in reset.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (r_state == ST_BUSY) begin
            m_axis_tdata           = w_tdata_a[r_grant];
            m_axis_tstrb           = w_tstrb_a[r_grant];
            m_axis_tuser           = w_tuser_a[r_grant];
            m_axis_tvalid          = s_axis_tvalid[r_grant];
            m_axis_tlast           = s_axis_tlast[r_grant];
            s_axis_tready[r_grant] = m_axis_tready;
`ifdef AXIS_MUX_SRC_TAG_EN
            m_axis_tuser[SRC_TAG_LSB +: c_GW] = r_grant;
`endif
        end
    end

    logic w_hs_last;
    assign w_hs_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Arbitration FSM: grant in IDLE, hold the grant until the tlast handshake
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_CH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|s_axis_tvalid) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_hs_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state == ST_BUSY);
    assign grant_id = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_pkt_mux_rr
//  Description : Directed self-checking bench for axis_pkt_mux_rr
//                (NUM_CH=4, 64-bit data, 128-bit user).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_mux_rr;

    localparam int NUM_CH = 4;
    localparam int DW     = 64;
    localparam int UW     = 128;
    localparam int SW     = DW / 8;

    logic                 clk = 1'b0;
    logic                 arst;
    logic [NUM_CH*DW-1:0] s_axis_tdata;
    logic [NUM_CH*SW-1:0] s_axis_tstrb;
    logic [NUM_CH*UW-1:0] s_axis_tuser;
    logic [NUM_CH-1:0]    s_axis_tvalid;
    logic [NUM_CH-1:0]    s_axis_tlast;
    logic [NUM_CH-1:0]    s_axis_tready;
    logic [DW-1:0]        m_axis_tdata;
    logic [SW-1:0]        m_axis_tstrb;
    logic [UW-1:0]        m_axis_tuser;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;
    logic [1:0]           grant_id;
    logic                 busy;

    axis_pkt_mux_rr #(
        .NUM_CH      (NUM_CH),
        .DATA_WIDTH  (DW),
        .USER_WIDTH  (UW),
        .SRC_TAG_LSB (32)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source model state per channel
    int          src_pkts      [NUM_CH];
    int          src_len       [NUM_CH];
    int          src_beat      [NUM_CH];
    int          src_pidx      [NUM_CH];
    int          src_stall_at  [NUM_CH];
    int          src_stall_cnt [NUM_CH];
    bit          src_stall_done[NUM_CH];
    logic [UW-1:0] src_user    [NUM_CH];
    logic [NUM_CH-1:0] hs;
    bit          rdy_toggle;

    // Observed output beats
    logic [DW-1:0] obs_data [$];
    logic [SW-1:0] obs_strb [$];
    logic [UW-1:0] obs_user [$];
    bit            obs_last [$];
    int            obs_grant[$];
    int            obs_cyc  [$];

    function automatic logic [DW-1:0] beat_data(input int c, input int p, input int b);
        logic [7:0] c8, p8, b8;
        c8 = c[7:0];
        p8 = p[7:0];
        b8 = b[7:0];
        return {40'h0, c8, p8, b8};
    endfunction

    task automatic drive_src();
        for (int i = 0; i < NUM_CH; i++) begin
            s_axis_tvalid[i]          = (src_pkts[i] > 0) && (src_stall_cnt[i] == 0);
            s_axis_tlast[i]           = (src_beat[i] == src_len[i] - 1);
            s_axis_tdata[i*DW +: DW]  = beat_data(i, src_pidx[i], src_beat[i]);
            s_axis_tstrb[i*SW +: SW]  = (src_beat[i] == src_len[i] - 1) ? 8'h0F : 8'hFF;
            s_axis_tuser[i*UW +: UW]  = (src_beat[i] == 0) ? '0 : src_user[i];
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NUM_CH; i++) begin
            src_pkts[i]       = 0;
            src_len[i]        = 1;
            src_beat[i]       = 0;
            src_pidx[i]       = 0;
            src_stall_at[i]   = -1;
            src_stall_cnt[i]  = 0;
            src_stall_done[i] = 1'b0;
            src_user[i]       = '0;
        end
        obs_data.delete();
        obs_strb.delete();
        obs_user.delete();
        obs_last.delete();
        obs_grant.delete();
        obs_cyc.delete();
        cyc           = 0;
        rdy_toggle    = 1'b0;
        m_axis_tready = 1'b1;
        drive_src();
    endtask

    // Sample at the falling edge: record the beat that the next rising edge accepts
    task automatic tick_pre();
        @(negedge clk);
        cyc++;
        hs = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            obs_data.push_back(m_axis_tdata);
            obs_strb.push_back(m_axis_tstrb);
            obs_user.push_back(m_axis_tuser);
            obs_last.push_back(m_axis_tlast);
            obs_grant.push_back(int'(grant_id));
            obs_cyc.push_back(cyc);
        end
    endtask

    // Advance sources after the rising edge according to the sampled handshakes
    task automatic tick_post();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_stall_cnt[i] > 0) begin
                src_stall_cnt[i]--;
            end else if (hs[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_pkts[i]--;
                    src_pidx[i]++;
                end else begin
                    src_beat[i]++;
                    if (src_beat[i] == src_stall_at[i] && !src_stall_done[i]) begin
                        src_stall_cnt[i]  = 5;
                        src_stall_done[i] = 1'b1;
                    end
                end
            end
        end
        if (rdy_toggle) m_axis_tready = ~m_axis_tready;
        drive_src();
    endtask

    task automatic do_reset();
        arst = 1'b1;
        clear_src();
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        clear_src();
        src_pkts[1] = 1;
        src_len[1]  = 2;
        drive_src();
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 4'b0000 || m_axis_tvalid !== 1'b0 || busy !== 1'b0 ||
            grant_id !== 2'd0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_state tready=%b mvalid=%b busy=%b grant=%0d data=%h (exp 0000 0 0 0 0)",
                     s_axis_tready, m_axis_tvalid, busy, grant_id, m_axis_tdata);
        end
        @(posedge clk);
        #1;
        arst = 1'b0;
        tick_pre();
        checks++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b mvalid=%b exp 0 0", busy, m_axis_tvalid);
        end
        tick_post();
        tick_pre();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || m_axis_tvalid !== 1'b1 ||
            m_axis_tdata !== beat_data(1, 0, 0) || s_axis_tready !== 4'b0010) begin
            errors++;
            $display("FAIL reset_first_grant busy=%b grant=%0d mvalid=%b data=%h tready=%b exp 1 1 1 %h 0010",
                     busy, grant_id, m_axis_tvalid, m_axis_tdata, s_axis_tready, beat_data(1, 0, 0));
        end
        tick_post();
        for (int n = 0; n < 20 && obs_data.size() < 2; n++) begin
            tick_pre();
            tick_post();
        end
        checks++;
        if (obs_data.size() != 2 || obs_data[1] !== beat_data(1, 0, 1) || obs_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_pkt beats=%0d exp 2 (second beat/tlast wrong or missing)", obs_data.size());
        end
    endtask

    task automatic test_fairness();
        int ch, pidx, b;
        do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            src_pkts[i] = 2;
            src_len[i]  = 4;
        end
        drive_src();
        for (int n = 0; n < 100 && obs_data.size() < 32; n++) begin
            tick_pre();
            tick_post();
        end
        checks++;
        if (obs_data.size() != 32) begin
            errors++;
            $display("FAIL fair_count beats=%0d exp 32", obs_data.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                ch   = (k / 4) % 4;
                pidx = k / 16;
                b    = k % 4;
                checks++;
                if (obs_grant[k] != ch || obs_data[k] !== beat_data(ch, pidx, b)) begin
                    errors++;
                    $display("FAIL fair_order k=%0d grant=%0d data=%h exp grant=%0d data=%h",
                             k, obs_grant[k], obs_data[k], ch, beat_data(ch, pidx, b));
                end
                checks++;
                if (obs_last[k] !== (b == 3) || obs_strb[k] !== ((b == 3) ? 8'h0F : 8'hFF)) begin
                    errors++;
                    $display("FAIL fair_last_strb k=%0d last=%b strb=%h exp last=%b", k, obs_last[k], obs_strb[k], b == 3);
                end
                if (k > 0) begin
                    checks++;
                    if (obs_cyc[k] - obs_cyc[k-1] != ((b == 0) ? 2 : 1)) begin
                        errors++;
                        $display("FAIL fair_gap k=%0d gap=%0d exp %0d", k, obs_cyc[k] - obs_cyc[k-1], (b == 0) ? 2 : 1);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        src_pkts[2] = 1;
        src_len[2]  = 8;
        rdy_toggle  = 1'b1;
        drive_src();
        for (int n = 0; n < 60 && obs_data.size() < 8; n++) begin
            tick_pre();
            if (busy) begin
                checks++;
                if (s_axis_tready !== {1'b0, m_axis_tready, 2'b00} || grant_id !== 2'd2) begin
                    errors++;
                    $display("FAIL bp_tready tready=%b grant=%0d mready=%b exp 0%b00 grant 2",
                             s_axis_tready, grant_id, m_axis_tready, m_axis_tready);
                end
            end
            tick_post();
        end
        checks++;
        if (obs_data.size() != 8) begin
            errors++;
            $display("FAIL bp_count beats=%0d exp 8", obs_data.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_data[k] !== beat_data(2, 0, k) || obs_last[k] !== (k == 7)) begin
                    errors++;
                    $display("FAIL bp_beat k=%0d data=%h last=%b exp %h %b",
                             k, obs_data[k], obs_last[k], beat_data(2, 0, k), k == 7);
                end
            end
        end
    endtask

    task automatic test_stall();
        int stall_cycles, bad_grant;
        stall_cycles = 0;
        bad_grant    = 0;
        do_reset();
        src_pkts[0]     = 1;
        src_len[0]      = 6;
        src_stall_at[0] = 3;
        src_pkts[3]     = 1;
        src_len[3]      = 2;
        drive_src();
        for (int n = 0; n < 80 && obs_data.size() < 8; n++) begin
            tick_pre();
            if (busy && !m_axis_tvalid) begin
                stall_cycles++;
                if (grant_id !== 2'd0) bad_grant++;
            end
            tick_post();
        end
        checks++;
        if (stall_cycles != 5 || bad_grant != 0) begin
            errors++;
            $display("FAIL stall_hold stall_cycles=%0d bad_grant=%0d exp 5 0", stall_cycles, bad_grant);
        end
        checks++;
        if (obs_data.size() != 8) begin
            errors++;
            $display("FAIL stall_count beats=%0d exp 8", obs_data.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if ((k < 6 && (obs_grant[k] != 0 || obs_data[k] !== beat_data(0, 0, k))) ||
                    (k >= 6 && (obs_grant[k] != 3 || obs_data[k] !== beat_data(3, 0, k - 6)))) begin
                    errors++;
                    $display("FAIL stall_seq k=%0d grant=%0d data=%h", k, obs_grant[k], obs_data[k]);
                end
            end
        end
    endtask

    task automatic test_single_beat_wrap();
        do_reset();
        src_pkts[0] = 4;
        src_len[0]  = 1;
        drive_src();
        for (int n = 0; n < 40 && obs_data.size() < 4; n++) begin
            tick_pre();
            tick_post();
        end
        checks++;
        if (obs_data.size() != 4) begin
            errors++;
            $display("FAIL single_count beats=%0d exp 4", obs_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_grant[k] != 0 || obs_last[k] !== 1'b1 || obs_data[k] !== beat_data(0, k, 0) ||
                    obs_strb[k] !== 8'h0F) begin
                    errors++;
                    $display("FAIL single_beat k=%0d grant=%0d last=%b data=%h strb=%h exp 0 1 %h 0f",
                             k, obs_grant[k], obs_last[k], obs_data[k], obs_strb[k], beat_data(0, k, 0));
                end
                if (k > 0) begin
                    checks++;
                    if (obs_cyc[k] - obs_cyc[k-1] != 2) begin
                        errors++;
                        $display("FAIL single_gap k=%0d gap=%0d exp 2", k, obs_cyc[k] - obs_cyc[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_tag();
        logic [UW-1:0] exp0, exp1;
`ifdef AXIS_MUX_SRC_TAG_EN
        exp0 = 128'h3_0000_0000;
        exp1 = 128'h3_DEAD_BEEF;
`else
        exp0 = 128'h0;
        exp1 = 128'hDEAD_BEEF;
`endif
        do_reset();
        src_pkts[3] = 1;
        src_len[3]  = 2;
        src_user[3] = 128'hDEAD_BEEF;
        drive_src();
        for (int n = 0; n < 20 && obs_data.size() < 2; n++) begin
            tick_pre();
            tick_post();
        end
        checks++;
        if (obs_data.size() != 2) begin
            errors++;
            $display("FAIL tag_count beats=%0d exp 2", obs_data.size());
        end else begin
            checks++;
            if (obs_user[0] !== exp0 || obs_grant[0] != 3) begin
                errors++;
                $display("FAIL tag_beat0 user=%h grant=%0d exp %h 3", obs_user[0], obs_grant[0], exp0);
            end
            checks++;
            if (obs_user[1] !== exp1) begin
                errors++;
                $display("FAIL tag_beat1 user=%h exp %h", obs_user[1], exp1);
            end
        end
    endtask

    initial begin
        arst          = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_stall();
        test_single_beat_wrap();
        test_tag();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
